adc_spi_req_arbiter: RTL and testbench
======================================

// Module: adc_spi_req_arbiter
// PURPOSE
//  Shares the single AD9680 3-wire SPI transaction engine among NUM_REQ requesters.
//  Requesters are the AXI-lite host path, the periodic status poller and the init sequencer.
//  Accepts one register read/write at a time and grants round-robin.
//  Launches the transaction, waits for completion or timeout, and returns the result to the granted requester only.
//  Sits between the requesters and the SPI engine driving ADC_CSB/ADC_SCLK/ADC_SDIO.
// PARAMETERS
//  NUM_REQ        2     number of requesters, 2..4
//  ADDR_WIDTH     15    SPI register address width
//  DATA_WIDTH     8     SPI register data width
//  TIMEOUT_CYCLES 4096  max CLK cycles in WAIT before abort; >=2
// PORTS
//  CLK        in   1                    system clock, all logic on rising edge
//  RESET      in   1                    synchronous, active-high
//  REQ_VALID  in   NUM_REQ              per-requester request valid
//  REQ_READY  out  NUM_REQ              per-requester accept (one-hot or zero)
//  REQ_RNW    in   NUM_REQ              1=read, 0=write
//  REQ_ADDR   in   NUM_REQ*ADDR_WIDTH   packed addresses, requester i at [i*AW +: AW]
//  REQ_WDATA  in   NUM_REQ*DATA_WIDTH   packed write data
//  RSP_VALID  out  NUM_REQ              one-cycle completion pulse to owner
//  RSP_RDATA  out  DATA_WIDTH           read data, valid with RSP_VALID
//  RSP_ERR    out  1                    1=timeout, valid with RSP_VALID
//  SPI_START  out  1                    one-cycle launch pulse to SPI engine
//  SPI_RNW    out  1                    latched op direction
//  SPI_ADDR   out  ADDR_WIDTH           latched address
//  SPI_WDATA  out  DATA_WIDTH           latched write data
//  SPI_DONE   in   1                    one-cycle completion pulse from engine
//  SPI_RDATA  in   DATA_WIDTH           engine read data, valid with SPI_DONE
//  GRANT_ID   out  $clog2(NUM_REQ)      current/last owner index
//  BUSY       out  1                    1 when state != IDLE
//  TIMEOUT_CNT out 8                    saturating count of timed-out transactions
// BEHAVIOUR
//  Reset values:
//   - State=IDLE; all outputs 0.
//   - last_grant=NUM_REQ-1, so requester 0 wins first.
//   - TIMEOUT_CNT=0.
//   - Reset in any state aborts immediately; no RSP_VALID is issued for the aborted op.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE:
//   - Winner = first i with REQ_VALID[i], searching from last_grant+1 with wrap modulo NUM_REQ.
//   - REQ_READY is combinational: one-hot on the winner, only in IDLE.
//   - On VALID&READY: latch RNW/ADDR/WDATA into SPI_*, set GRANT_ID=winner and last_grant=winner, go to ISSUE.
//  ISSUE: SPI_START=1 for exactly this cycle; clear timer; go to WAIT.
//  WAIT:
//   - On SPI_DONE: capture SPI_RDATA (reads) or 0 (writes), ERR=0, go to RESP.
//   - Timer counts from 1 each WAIT cycle. When timer==TIMEOUT_CYCLES with no SPI_DONE: RDATA=0, ERR=1, TIMEOUT_CNT+1 (saturates at 255), go to RESP.
//   - If SPI_DONE and the timeout coincide in the same cycle, SPI_DONE wins and ERR=0.
//  RESP: RSP_VALID[GRANT_ID]=1 for one cycle; go to IDLE. No new grant is made in this cycle.
//  Latency: accept at T; SPI_START at T+1; SPI_DONE at D gives RSP_VALID at D+1; next grant earliest at D+2.
//  SPI_DONE outside WAIT is ignored. SPI_* hold stable from ISSUE through RESP.
//  Requester dropping REQ_VALID before grant: not an error; it is simply skipped.
//  RSP_RDATA/RSP_ERR hold their value until the next RESP.
// CONFIGURATION
//  ADC_SPI_ARB_PRIORITY_EN:
//   - Defined: fixed priority; the lowest index with REQ_VALID wins and last_grant is unused.
//     Requester 0 (host) can starve the others.
//   - Undefined (default): round-robin as above.
// TESTING
//  1. Single write, NUM_REQ=2: req0 addr=0x0014 wdata=0x5A; engine DONE 10 cycles after START
//     -> START at T+1, SPI_ADDR=0x0014, RSP_VALID=2'b01 at DONE+1, ERR=0.
//  2. Read: req1 RNW=1 addr=0x0001; engine returns 0xC5 -> RSP_VALID=2'b10, RSP_RDATA=0xC5.
//  3. Both VALID held for 4 ops -> grants 0,1,0,1 (default) / 0,0,0,0 (PRIORITY_EN defined).
//  4. Engine never asserts DONE, TIMEOUT_CYCLES=16 -> RSP_VALID exactly 16 cycles after START+1,
//     ERR=1, RDATA=0, TIMEOUT_CNT=1.
//  5. DONE on the timeout cycle -> ERR=0, TIMEOUT_CNT unchanged; stray DONE in IDLE -> no RSP_VALID.
//  6. RESET asserted in WAIT -> next cycle IDLE, BUSY=0, no RSP_VALID; next grant goes to req0.

Source files
------------

// File: rtl/adc_spi_req_arbiter.sv
// adc_spi_req_arbiter: shares one AD9680 3-wire SPI transaction engine among NUM_REQ requesters.
// Round-robin by default; define ADC_SPI_ARB_PRIORITY_EN for fixed priority (lowest index wins).
module adc_spi_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 15,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic [NUM_REQ-1:0]            REQ_RNW,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA,
    output logic [NUM_REQ-1:0]            RSP_VALID,
    output logic [DATA_WIDTH-1:0]         RSP_RDATA,
    output logic                          RSP_ERR,
    output logic                          SPI_START,
    output logic                          SPI_RNW,
    output logic [ADDR_WIDTH-1:0]         SPI_ADDR,
    output logic [DATA_WIDTH-1:0]         SPI_WDATA,
    input  logic                          SPI_DONE,
    input  logic [DATA_WIDTH-1:0]         SPI_RDATA,
    output logic [$clog2(NUM_REQ)-1:0]    GRANT_ID,
    output logic                          BUSY,
    output logic [7:0]                    TIMEOUT_CNT
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [GW-1:0]           grant_q;
    logic                    spi_start_q;
    logic                    spi_rnw_q;
    logic [ADDR_WIDTH-1:0]   spi_addr_q;
    logic [DATA_WIDTH-1:0]   spi_wdata_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic [7:0]              timeout_cnt_q;
    logic [TW-1:0]           timer_q;
    logic [TW-1:0]           timer_d;
    logic                    timeout_hit;
    logic [GW-1:0]           winner;
    logic                    any_req;
`ifndef ADC_SPI_ARB_PRIORITY_EN
    logic [GW-1:0]           last_grant_q;
`endif

    assign any_req = |REQ_VALID;

    always_comb begin
        winner = '0;
`ifdef ADC_SPI_ARB_PRIORITY_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (REQ_VALID[i]) winner = GW'(i);
        end
`else
        // Scan farthest-first so the nearest valid requester after last_grant overwrites the rest.
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (REQ_VALID[(int'(last_grant_q) + k) % NUM_REQ])
                winner = GW'((int'(last_grant_q) + k) % NUM_REQ);
        end
`endif
    end

    // Handshake: a request transfers on a cycle where REQ_VALID[i] and REQ_READY[i] are both high;
    // READY is only offered in IDLE, one-hot on the winner, and never depends on anything but VALID.
    always_comb begin
        REQ_READY = '0;
        if (state_q == ST_IDLE && any_req) REQ_READY[winner] = 1'b1;
    end

    assign timer_d     = timer_q + 1'b1;
    assign timeout_hit = (timer_d == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            spi_start_q   <= 1'b0;
            spi_rnw_q     <= 1'b0;
            spi_addr_q    <= '0;
            spi_wdata_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            timeout_cnt_q <= '0;
            timer_q       <= '0;
`ifndef ADC_SPI_ARB_PRIORITY_EN
            last_grant_q  <= GW'(NUM_REQ - 1);
`endif
        end else begin
            spi_start_q <= 1'b0;
            rsp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        spi_rnw_q    <= REQ_RNW[winner];
                        spi_addr_q   <= REQ_ADDR[winner*ADDR_WIDTH +: ADDR_WIDTH];
                        spi_wdata_q  <= REQ_WDATA[winner*DATA_WIDTH +: DATA_WIDTH];
                        grant_q      <= winner;
`ifndef ADC_SPI_ARB_PRIORITY_EN
                        last_grant_q <= winner;
`endif
                        spi_start_q  <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer_q <= timer_d;
                    // A completion on the timeout cycle still counts as a success.
                    if (SPI_DONE) begin
                        rsp_rdata_q          <= spi_rnw_q ? SPI_RDATA : '0;
                        rsp_err_q            <= 1'b0;
                        rsp_valid_q[grant_q] <= 1'b1;
                        state_q              <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata_q          <= '0;
                        rsp_err_q            <= 1'b1;
                        rsp_valid_q[grant_q] <= 1'b1;
                        if (timeout_cnt_q != 8'hFF) timeout_cnt_q <= timeout_cnt_q + 8'd1;
                        state_q              <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign SPI_START   = spi_start_q;
    assign SPI_RNW     = spi_rnw_q;
    assign SPI_ADDR    = spi_addr_q;
    assign SPI_WDATA   = spi_wdata_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_ERR     = rsp_err_q;
    assign GRANT_ID    = grant_q;
    assign BUSY        = (state_q != ST_IDLE);
    assign TIMEOUT_CNT = timeout_cnt_q;

endmodule

// File: tb/tb_adc_spi_req_arbiter.sv
// tb_adc_spi_req_arbiter: self-checking bench for adc_spi_req_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=16).
// Expected responses are queued at acceptance and popped by the response monitor.
module tb_adc_spi_req_arbiter;

    localparam int NR = 2;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int TO = 16;
    // Queue entry: {rsp_cycle[15:0], rsp_onehot[1:0], err, rdata[7:0]}
    localparam int EW = 27;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_rnw = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             spi_start;
    logic             spi_rnw;
    logic [AW-1:0]    spi_addr;
    logic [DW-1:0]    spi_wdata;
    logic             spi_done = 1'b0;
    logic [DW-1:0]    spi_rdata = '0;
    logic [0:0]       grant_id;
    logic             busy;
    logic [7:0]       timeout_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tb_last = NR - 1;
    logic [EW-1:0] exp_q[$];

    adc_spi_req_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(clk), .RESET(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_RNW(req_rnw),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
        .SPI_START(spi_start), .SPI_RNW(spi_rnw), .SPI_ADDR(spi_addr), .SPI_WDATA(spi_wdata),
        .SPI_DONE(spi_done), .SPI_RDATA(spi_rdata),
        .GRANT_ID(grant_id), .BUSY(busy), .TIMEOUT_CNT(timeout_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // response monitor / scoreboard
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check_val("unexp_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check_val("rsp_valid", 32'(rsp_valid), 32'(e[10:9]));
                check_val("rsp_err", 32'(rsp_err), 32'(e[8]));
                check_val("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
                check_val("rsp_cycle", 32'(cyc[15:0]), 32'(e[26:11]));
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("rsp_seen", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // dly >= 1: engine DONE dly cycles after START; dly < 0: engine never answers
    task automatic issue_op(input int r, input logic rnw, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input int dly, input logic [DW-1:0] rd);
        int n, t;
        logic [1:0] oh;
        logic [DW-1:0] exp_rd;
        @(posedge clk); #1;
        req_valid[r] = 1'b1;
        req_rnw[r] = rnw;
        req_addr[r*AW +: AW] = addr;
        req_wdata[r*DW +: DW] = wd;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        oh = 2'(1 << r);
        check_val("req_ready", 32'(req_ready), 32'(oh));
        t = cyc;
        exp_rd = (dly >= 0 && rnw) ? rd : '0;
        exp_q.push_back({16'(t + 2 + ((dly >= 0) ? dly : TO)), oh, (dly < 0), exp_rd});
        tb_last = r;
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        @(negedge clk);
        check_val("spi_start", 32'(spi_start), 32'd1);
        check_val("spi_addr", 32'(spi_addr), 32'(addr));
        check_val("spi_rnw", 32'(spi_rnw), 32'(rnw));
        check_val("spi_wdata", 32'(spi_wdata), 32'(wd));
        check_val("grant_id", 32'(grant_id), r);
        check_val("busy", 32'(busy), 32'd1);
        if (dly >= 0) begin
            repeat (dly) @(posedge clk);
            #1;
            spi_done = 1'b1;
            spi_rdata = rd;
            @(negedge clk);
            check_val("spi_addr_hold", 32'(spi_addr), 32'(addr));
            @(posedge clk); #1;
            spi_done = 1'b0;
            spi_rdata = '0;
        end
        drain();
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_spi_start", 32'(spi_start), 32'd0);
        check_val("rst_grant", 32'(grant_id), 32'd0);
        check_val("rst_tocnt", 32'(timeout_cnt), 32'd0);
        check_val("rst_spi_addr", 32'(spi_addr), 32'd0);

        // single write, then read on requester 1
        issue_op(0, 1'b0, 15'h0014, 8'h5A, 10, 8'h00);
        issue_op(1, 1'b1, 15'h0001, 8'h00, 4, 8'hC5);
        @(negedge clk);
        check_val("rdata_hold", 32'(rsp_rdata), 32'hC5);

        // both requesters held for four ops
        @(posedge clk); #1;
        req_rnw = '0;
        req_addr = {15'h0201, 15'h0100};
        req_wdata = {8'h22, 8'h11};
        req_valid = 2'b11;
        @(negedge clk);
        for (int op = 0; op < 4; op++) begin
            int n, t, w;
`ifdef ADC_SPI_ARB_PRIORITY_EN
            w = 0;
`else
            w = (tb_last + 1) % NR;
`endif
            n = 0;
            while (req_ready == '0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check_val("arb_ready", 32'(req_ready), 32'(1 << w));
            t = cyc;
            exp_q.push_back({16'(t + 2 + 3), 2'(1 << w), 1'b0, 8'h00});
            tb_last = w;
            @(posedge clk); #1;
            if (op == 3) req_valid = '0;
            @(negedge clk);
            check_val("arb_grant", 32'(grant_id), w);
            check_val("arb_addr", 32'(spi_addr), (w == 1) ? 32'h201 : 32'h100);
            repeat (3) @(posedge clk);
            #1 spi_done = 1'b1;
            @(posedge clk);
            #1 spi_done = 1'b0;
            drain();
        end

        // engine silent -> timeout
        issue_op(0, 1'b1, 15'h0002, 8'h00, -1, 8'hEE);
        check_val("tocnt_after_to", 32'(timeout_cnt), 32'd1);
        check_val("err_hold", 32'(rsp_err), 32'd1);

        // DONE on the timeout cycle wins
        issue_op(0, 1'b1, 15'h0003, 8'h00, TO, 8'h3C);
        check_val("tocnt_after_race", 32'(timeout_cnt), 32'd1);

        // stray DONE in IDLE
        @(posedge clk); #1 spi_done = 1'b1;
        @(posedge clk); #1 spi_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("stray_rsp", 32'(rsp_valid), 32'd0);
            check_val("stray_busy", 32'(busy), 32'd0);
        end

        // random traffic
        for (int i = 0; i < 6; i++) begin
            issue_op($urandom_range(0, NR - 1), 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 32767)), DW'($urandom_range(0, 255)),
                     $urandom_range(1, 12), DW'($urandom_range(0, 255)));
        end

        // reset during WAIT aborts silently; next grant goes to requester 0
        @(posedge clk); #1;
        req_valid = 2'b10;
        @(negedge clk);
        check_val("pre_rst_ready", 32'(req_ready), 32'b10);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_tocnt", 32'(timeout_cnt), 32'd0);
        check_val("abort_grant", 32'(grant_id), 32'd0);
        repeat (3) begin
            check_val("abort_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        tb_last = NR - 1;
        @(posedge clk); #1;
        req_rnw = '0;
        req_valid = 2'b11;
        @(negedge clk);
        check_val("post_rst_ready", 32'(req_ready), 32'b01);
        exp_q.push_back({16'(cyc + 2 + 2), 2'b01, 1'b0, 8'h00});
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 spi_done = 1'b1;
        @(posedge clk);
        #1 spi_done = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
